// File: rtl/cond_exec_unit.sv
// ============================================================================
// Module  : cond_exec_unit
// Brief   : E-stage conditional-execution sequencer. It holds NZCV, evaluates the condition,
//           gates the side effects and runs the post-branch squash.
//           Optional NV trap output enabled by defining COND_NV_TRAP_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module cond_exec_unit #(
  parameter int         FLUSH_CYCLES = 2,
  parameter logic [3:0] RESET_FLAGS  = 4'b0000
) (
  input  logic       CLK,
  input  logic       Reset,
  input  logic       ValidE,
  input  logic       StallE,
  input  logic [3:0] CondE,
  input  logic [1:0] FlagWriteE,
  input  logic [3:0] ALUFlags,
  input  logic       RegWriteE,
  input  logic       MemWriteE,
  input  logic       PCSrcE,
  input  logic       BranchE,
  output logic [3:0] Flags,
  output logic       CondExE,
  output logic       RegWriteG,
  output logic       MemWriteG,
  output logic       BranchTakenE,
  output logic       FlushD,
  output logic       FlushE,
  output logic       Busy,
  output logic       UndefE
);

  typedef enum logic [0:0] {
    S_RUN    = 1'b0,
    S_SQUASH = 1'b1
  } state_t;

  localparam logic [2:0] C_FLUSH_LOAD = 3'(FLUSH_CYCLES);

  state_t     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [3:0] flags_q, flags_d;
  logic       w_eff;
  logic       w_n, w_z, w_c, w_v;

  assign {w_n, w_z, w_c, w_v} = flags_q;

  always_comb begin
    CondExE = 1'b0;
    case (CondE)
      4'h0: CondExE = w_z;
      4'h1: CondExE = ~w_z;
      4'h2: CondExE = w_c;
      4'h3: CondExE = ~w_c;
      4'h4: CondExE = w_n;
      4'h5: CondExE = ~w_n;
      4'h6: CondExE = w_v;
      4'h7: CondExE = ~w_v;
      4'h8: CondExE = w_c & ~w_z;
      4'h9: CondExE = ~w_c | w_z;
      4'hA: CondExE = (w_n == w_v);
      4'hB: CondExE = (w_n != w_v);
      4'hC: CondExE = ~w_z & (w_n == w_v);
      4'hD: CondExE = w_z | (w_n != w_v);
      4'hE: CondExE = 1'b1;
      default: CondExE = 1'b0;
    endcase
  end

  assign w_eff        = ValidE & ~StallE & (state_q == S_RUN) & CondExE & ~Reset;
  assign RegWriteG    = w_eff & RegWriteE;
  assign MemWriteG    = w_eff & MemWriteE;
  assign BranchTakenE = w_eff & (BranchE | PCSrcE);
  assign Flags        = flags_q;

  // Reset forces the squash-related outputs low even while the state flop still says SQUASH.
  assign Busy   = ~Reset & (state_q == S_SQUASH);
  assign FlushD = BranchTakenE;
  assign FlushE = ~Reset & ((state_q == S_SQUASH) | BranchTakenE);

`ifdef COND_NV_TRAP_EN
  assign UndefE = ValidE & ~StallE & (state_q == S_RUN) & (CondE == 4'b1111) & ~Reset;
`else
  assign UndefE = 1'b0;
`endif

  always_comb begin
    flags_d = flags_q;
    if (w_eff && FlagWriteE[1]) flags_d[3:2] = ALUFlags[3:2];
    if (w_eff && FlagWriteE[0]) flags_d[1:0] = ALUFlags[1:0];
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_RUN: begin
        if (BranchTakenE && (FLUSH_CYCLES > 0)) begin
          state_d = S_SQUASH;
          cnt_d   = C_FLUSH_LOAD;
        end
      end
      S_SQUASH: begin
        if (!StallE) begin
          if (cnt_q == 3'd1) begin
            state_d = S_RUN;
            cnt_d   = 3'd0;
          end else begin
            cnt_d = cnt_q - 3'd1;
          end
        end
      end
      default: begin
        state_d = S_RUN;
        cnt_d   = 3'd0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q <= S_RUN;
      cnt_q   <= 3'd0;
      flags_q <= RESET_FLAGS;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      flags_q <= flags_d;
    end
  end

endmodule

`default_nettype wire
